pipe_mw_stage: RTL and testbench
================================

Name: pipe_mw_stage

Overview:
- MEM/WB boundary of the 5-stage MIPS32 pipeline.
- Captures the memory-stage results: ALU result, memory/IO read data, destination register, and the write/load controls.
- Presents writeback data to the register file.
- Feeds wm2reg/wmo back to the memory stage for load-then-store data forwarding.
- Handles stall (hold), flush (bubble), write suppression for $0, and an optional retired-instruction counter.

Parameters:
- DATA_W, 32, datapath width
- RN_W, 5, register-number width
- CNT_W, 32, retired-instruction counter width (used only with the optional feature)

Ports:
- clock  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hold all stage registers this cycle
- flush  in  1  insert a bubble at this cycle's capture edge
- mvalid  in  1  MEM-stage instruction is real (not a bubble)
- mwreg  in  1  MEM instruction writes the register file
- mm2reg  in  1  MEM instruction is a load (writeback from memory)
- mrn  in  RN_W  MEM destination register
- malu  in  DATA_W  MEM ALU result / address
- mmo  in  DATA_W  MEM read data (RAM or IO mux output)
- wvalid  out  1  WB instruction valid
- wwreg  out  1  register-file write enable, already qualified
- wm2reg  out  1  WB is a load (also fed back to MEM)
- wrn  out  RN_W  WB destination register
- walu  out  DATA_W  registered ALU result
- wmo  out  DATA_W  registered memory data (also fed back to MEM)
- wdi  out  DATA_W  writeback data to the register file
- retired  out  CNT_W  retired count (only with RETIRE_CNT_EN)

Behaviour:
- Reset (async, active-high): wvalid, wm2reg, wrn, walu and wmo all clear to 0 immediately, without waiting for a clock edge. wwreg=0 and wdi=0 follow. Reset mid-stall or mid-flush wins.
- Edge priority at posedge clock: reset > flush > stall > capture.
- flush=1:
  - wvalid<=0, internal write enable<=0, wm2reg<=0.
  - wrn, walu, wmo hold their values (don't-care, not updated).
  - Flush overrides a simultaneous stall.
- stall=1 (no flush): every register holds. Output is stable for as many cycles as stall stays asserted.
- Capture (stall=0, flush=0):
  - wvalid<=mvalid; wm2reg<=mm2reg & mvalid.
  - Internal write enable<=mwreg & mvalid.
  - wrn<=mrn, walu<=malu, wmo<=mmo.
  - Latency: one cycle from MEM inputs to W outputs.
- wwreg is combinational: registered write enable & wvalid & (wrn != 0). A write to $0 never reaches the register file.
- wdi is combinational: wm2reg ? wmo : walu. It follows the registers in the same cycle.
- Bubble entry (mvalid=0): captured as wvalid=0, wwreg=0, wm2reg=0. Data fields are captured but ignored.
- No arithmetic on the datapath; widths pass through unchanged.

Optional Feature:
- RETIRE_CNT_EN defined:
  - CNT_W-bit register `retired`, reset to 0.
  - Increments by 1 on each capture edge where mvalid=1.
  - No increment on stall, flush or bubble edges.
  - Wraps from all-ones to 0 with no saturation or flag.
- RETIRE_CNT_EN undefined: no counter logic; `retired` is driven constant 0.

Decomposition:
- Shared package pipe_pkg: DATA_W/RN_W defaults, REG_ZERO constant (5'd0), and the reset value of the stage-register bundle.
- One natural sub-module, pipe_reg_ce: a parameterised-width register with async active-high reset, synchronous clear, and clock enable.
  - Instantiated for the control bundle {valid, wreg, m2reg}: clear=flush, enable=~stall.
  - Instantiated for the data bundle {rn, alu, mo}: clear=0, enable=~stall & ~flush.
- The wwreg/wdi combinational logic and the optional counter stay in pipe_mw_stage.

Test Plan:
- Reset during traffic:
  - Stimulus: assert reset mid-cycle while wvalid=1, walu=32'hDEAD_BEEF.
  - Required: all outputs 0 before the next edge; retired=0 with the feature on.
- ALU write:
  - Stimulus: mvalid=1, mwreg=1, mm2reg=0, mrn=5'd8, malu=32'h0000_0080, mmo=32'h1234_5678; one edge.
  - Required: wwreg=1, wrn=8, wdi=32'h0000_0080.
- Load:
  - Stimulus: same instruction with mm2reg=1.
  - Required: wm2reg=1, wdi=wmo=32'h1234_5678.
- Write to $0 suppressed:
  - Stimulus: mrn=0, mwreg=1, mvalid=1.
  - Required: wvalid=1 but wwreg=0.
- Stall then flush:
  - Stimulus: capture instruction A (mrn=9, wreg), then stall=1 for 3 cycles with different inputs, then stall=1 and flush=1 together.
  - Required: A held for 3 cycles; next edge gives wvalid=0, wwreg=0; retired unchanged.
- Counter wrap (RETIRE_CNT_EN, CNT_W=4):
  - Stimulus: 17 valid captures interleaved with 2 bubbles and 1 stall.
  - Required: retired=4'd1 (wrapped once after 16 captures).

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: definitions shared by the MIPS32 pipeline stage registers.
//   DEF_DATA_W / DEF_RN_W : default datapath and register-number widths
//   REG_ZERO              : register number of the hardwired-zero register $0
//   mw_ctrl_t / MW_CTRL_RST : MEM/WB control bundle and its reset value
package pipe_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_RN_W   = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Control half of the MEM/WB stage register. Both fields are already
  // qualified with valid when they are captured, so a bubble carries zeros.
  typedef struct packed {
    logic valid;
    logic wreg;
    logic m2reg;
  } mw_ctrl_t;

  localparam mw_ctrl_t MW_CTRL_RST = '{valid: 1'b0, wreg: 1'b0, m2reg: 1'b0};

endpackage

// File: rtl/pipe_mw_stage_if.sv
// pipe_mw_stage_if: signal bundle between the MEM stage and the MEM/WB
// boundary register.
//   master : MEM side; drives stall/flush and the m* fields, sees the w* fields
//   slave  : the stage register; consumes the m* fields, drives w* and retired
//
// Pipeline control (one rule for the whole bundle): at a rising clock edge
// flush inserts a bubble and beats stall; stall holds every register; with
// neither asserted the m* fields are captured and appear on w* one cycle later.
// There is no back-pressure beyond stall: the stage always accepts.
interface pipe_mw_stage_if #(
  parameter int DATA_W = 32,
  parameter int RN_W   = 5,
  parameter int CNT_W  = 32
) ();

  logic              stall;
  logic              flush;
  logic              mvalid;
  logic              mwreg;
  logic              mm2reg;
  logic [RN_W-1:0]   mrn;
  logic [DATA_W-1:0] malu;
  logic [DATA_W-1:0] mmo;

  logic              wvalid;
  logic              wwreg;
  logic              wm2reg;
  logic [RN_W-1:0]   wrn;
  logic [DATA_W-1:0] walu;
  logic [DATA_W-1:0] wmo;
  logic [DATA_W-1:0] wdi;
  logic [CNT_W-1:0]  retired;

  modport master (
    output stall, flush, mvalid, mwreg, mm2reg, mrn, malu, mmo,
    input  wvalid, wwreg, wm2reg, wrn, walu, wmo, wdi, retired
  );

  modport slave (
    input  stall, flush, mvalid, mwreg, mm2reg, mrn, malu, mmo,
    output wvalid, wwreg, wm2reg, wrn, walu, wmo, wdi, retired
  );

endinterface

// File: rtl/pipe_reg_ce.sv
// pipe_reg_ce: W-bit pipeline register.
//   clock : rising-edge clock
//   reset : asynchronous, active-high; loads RST_VAL immediately
//   clear : synchronous; loads RST_VAL at the edge, overrides en
//   en    : clock enable; q <= d when set (and clear is low)
//   d / q : data in / registered data out
module pipe_reg_ce #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= RST_VAL;
    end else if (clear) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_mw_stage.sv
// pipe_mw_stage: MEM/WB boundary of the 5-stage MIPS32 pipeline.
//   clock : rising-edge pipeline clock
//   reset : asynchronous, active-high
//   mw    : pipe_mw_stage_if.slave
//             in : stall, flush, mvalid, mwreg, mm2reg, mrn, malu, mmo
//             out: wvalid, wwreg (qualified RF write enable), wm2reg, wrn,
//                  walu, wmo, wdi (writeback data), retired
// wm2reg/wmo are also fed back to MEM for load-then-store forwarding.
//
// Optional feature macro RETIRE_CNT_EN: when defined, `retired` counts
// instructions captured with mvalid=1 (CNT_W bits, wraps). When undefined,
// `retired` is tied to 0.
module pipe_mw_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int RN_W   = DEF_RN_W,
  parameter int CNT_W  = 32
) (
  input  logic           clock,
  input  logic           reset,
  pipe_mw_stage_if.slave mw
);

  localparam int DBUS_W = RN_W + 2 * DATA_W;

  mw_ctrl_t          ctrl_d;
  mw_ctrl_t          ctrl_q;
  logic [DBUS_W-1:0] data_d;
  logic [DBUS_W-1:0] data_q;
  logic              capture;

  assign capture = ~mw.stall & ~mw.flush;

  // Controls are qualified with mvalid on the way in so a bubble can never
  // write the register file or select memory data.
  always_comb begin
    ctrl_d       = MW_CTRL_RST;
    ctrl_d.valid = mw.mvalid;
    ctrl_d.wreg  = mw.mwreg & mw.mvalid;
    ctrl_d.m2reg = mw.mm2reg & mw.mvalid;
  end

  assign data_d = {mw.mrn, mw.malu, mw.mmo};

  // Flush clears the control bundle even during a stall.
  pipe_reg_ce #(
    .W       ($bits(mw_ctrl_t)),
    .RST_VAL (MW_CTRL_RST)
  ) u_ctrl_reg (
    .clock (clock),
    .reset (reset),
    .clear (mw.flush),
    .en    (~mw.stall),
    .d     (ctrl_d),
    .q     (ctrl_q)
  );

  // Data fields are don't-care behind a bubble, so flush just holds them.
  pipe_reg_ce #(
    .W       (DBUS_W),
    .RST_VAL ('0)
  ) u_data_reg (
    .clock (clock),
    .reset (reset),
    .clear (1'b0),
    .en    (capture),
    .d     (data_d),
    .q     (data_q)
  );

  assign mw.wvalid = ctrl_q.valid;
  assign mw.wm2reg = ctrl_q.m2reg;
  assign mw.wrn    = data_q[DBUS_W-1 -: RN_W];
  assign mw.walu   = data_q[2*DATA_W-1 -: DATA_W];
  assign mw.wmo    = data_q[DATA_W-1:0];

  // $0 is hardwired to zero; a write to it must never reach the register file.
  assign mw.wwreg = ctrl_q.wreg & ctrl_q.valid & (mw.wrn != RN_W'(REG_ZERO));
  assign mw.wdi   = ctrl_q.m2reg ? mw.wmo : mw.walu;

`ifdef RETIRE_CNT_EN
  logic [CNT_W-1:0] retired_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      retired_q <= '0;
    end else if (capture && mw.mvalid) begin
      retired_q <= retired_q + 1'b1;
    end
  end

  assign mw.retired = retired_q;
`else
  assign mw.retired = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_mw_stage.sv
module tb_pipe_mw_stage;

  localparam int DATA_W = 32;
  localparam int RN_W   = 5;
  localparam int CNT_W  = 4;

  logic clock;
  logic reset;

  int n_checks = 0;
  int n_errors = 0;

  logic [CNT_W-1:0] ret_model = '0;

  pipe_mw_stage_if #(.DATA_W(DATA_W), .RN_W(RN_W), .CNT_W(CNT_W)) mw ();

  pipe_mw_stage #(.DATA_W(DATA_W), .RN_W(RN_W), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .mw    (mw)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CNT_W-1:0] exp_retired();
`ifdef RETIRE_CNT_EN
    return ret_model;
`else
    return '0;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic wr, input logic m2r,
                       input logic [RN_W-1:0] rn, input logic [DATA_W-1:0] alu,
                       input logic [DATA_W-1:0] mo);
    mw.mvalid = v;
    mw.mwreg  = wr;
    mw.mm2reg = m2r;
    mw.mrn    = rn;
    mw.malu   = alu;
    mw.mmo    = mo;
  endtask

  // One rising edge, then sample 1 time unit later.
  task automatic step();
    if (!mw.flush && !mw.stall && mw.mvalid) ret_model = ret_model + 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".wvalid"},  64'(mw.wvalid),  64'd0);
    check({tag, ".wwreg"},   64'(mw.wwreg),   64'd0);
    check({tag, ".wm2reg"},  64'(mw.wm2reg),  64'd0);
    check({tag, ".wrn"},     64'(mw.wrn),     64'd0);
    check({tag, ".walu"},    64'(mw.walu),    64'd0);
    check({tag, ".wmo"},     64'(mw.wmo),     64'd0);
    check({tag, ".wdi"},     64'(mw.wdi),     64'd0);
    check({tag, ".retired"}, 64'(mw.retired), 64'(exp_retired()));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset    = 1'b1;
    mw.stall = 1'b0;
    mw.flush = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    ret_model = '0;
    #1;
    check_all_zero("reset_init");
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // ALU write to $8
    drive(1'b1, 1'b1, 1'b0, 5'd8, 32'h0000_0080, 32'h1234_5678);
    step();
    check("alu.wvalid", 64'(mw.wvalid), 64'd1);
    check("alu.wwreg",  64'(mw.wwreg),  64'd1);
    check("alu.wm2reg", 64'(mw.wm2reg), 64'd0);
    check("alu.wrn",    64'(mw.wrn),    64'd8);
    check("alu.wdi",    64'(mw.wdi),    64'h0000_0080);
    check("alu.retired", 64'(mw.retired), 64'(exp_retired()));

    // Load: writeback from memory data
    drive(1'b1, 1'b1, 1'b1, 5'd8, 32'h0000_0080, 32'h1234_5678);
    step();
    check("load.wm2reg", 64'(mw.wm2reg), 64'd1);
    check("load.wmo",    64'(mw.wmo),    64'h1234_5678);
    check("load.wdi",    64'(mw.wdi),    64'h1234_5678);
    check("load.walu",   64'(mw.walu),   64'h0000_0080);
    check("load.wwreg",  64'(mw.wwreg),  64'd1);

    // Write to $0 is suppressed
    drive(1'b1, 1'b1, 1'b0, 5'd0, 32'h0000_0044, 32'h0);
    step();
    check("r0.wvalid", 64'(mw.wvalid), 64'd1);
    check("r0.wwreg",  64'(mw.wwreg),  64'd0);

    // Bubble with write/load controls set: controls masked, data captured
    drive(1'b0, 1'b1, 1'b1, 5'd3, 32'h0000_0033, 32'h0000_0077);
    step();
    check("bubble.wvalid", 64'(mw.wvalid), 64'd0);
    check("bubble.wwreg",  64'(mw.wwreg),  64'd0);
    check("bubble.wm2reg", 64'(mw.wm2reg), 64'd0);
    check("bubble.wrn",    64'(mw.wrn),    64'd3);
    check("bubble.wdi",    64'(mw.wdi),    64'h0000_0033);

    // Stall then flush: capture A, hold 3 cycles, then stall+flush
    drive(1'b1, 1'b1, 1'b0, 5'd9, 32'hAAAA_0009, 32'h0);
    step();
    check("stallA.wwreg", 64'(mw.wwreg), 64'd1);
    check("stallA.wrn",   64'(mw.wrn),   64'd9);
    mw.stall = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 5'd17, 32'h5555_5555, 32'h6666_6666);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall.wvalid",  64'(mw.wvalid),  64'd1);
      check("stall.wwreg",   64'(mw.wwreg),   64'd1);
      check("stall.wrn",     64'(mw.wrn),     64'd9);
      check("stall.wdi",     64'(mw.wdi),     64'hAAAA_0009);
      check("stall.retired", 64'(mw.retired), 64'(exp_retired()));
    end
    mw.flush = 1'b1;
    step();
    check("flush.wvalid",  64'(mw.wvalid),  64'd0);
    check("flush.wwreg",   64'(mw.wwreg),   64'd0);
    check("flush.wm2reg",  64'(mw.wm2reg),  64'd0);
    check("flush.wrn",     64'(mw.wrn),     64'd9);
    check("flush.retired", 64'(mw.retired), 64'(exp_retired()));
    mw.stall = 1'b0;
    mw.flush = 1'b0;

    // Reset mid-cycle during traffic
    drive(1'b1, 1'b1, 1'b1, 5'd12, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    step();
    check("pre_rst.walu",   64'(mw.walu),   64'hDEAD_BEEF);
    check("pre_rst.wvalid", 64'(mw.wvalid), 64'd1);
    #2;
    reset = 1'b1;
    ret_model = '0;
    #1;
    check_all_zero("reset_mid");
    @(negedge clock);
    reset = 1'b0;

    // Counter wrap: 17 valid captures, 2 bubbles, 1 stall
    for (int i = 0; i < 20; i++) begin
      mw.stall = (i == 14);
      if (i == 5 || i == 11) drive(1'b0, 1'b0, 1'b0, 5'd1, 32'(i), 32'h0);
      else                   drive(1'b1, 1'b1, 1'b0, 5'd1, 32'(i), 32'h0);
      step();
      check("wrap.retired", 64'(mw.retired), 64'(exp_retired()));
    end
    mw.stall = 1'b0;
`ifdef RETIRE_CNT_EN
    check("wrap.final", 64'(mw.retired), 64'd1);
`else
    check("wrap.final", 64'(mw.retired), 64'd0);
`endif
    check("wrap.walu", 64'(mw.walu), 64'd19);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
